aes_core_arbiter: RTL and testbench
===================================

Name: aes_core_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one iterative AES-128 encryption core among NUM_REQ requesters.
- Accepts a {block, key} job from one requester, launches the core, and waits for its done pulse. It then returns the ciphertext to the same requester over a valid/ready response channel.
- Sits between the requester-side ports and the single AES core instance. Only one job is in flight at any time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BLOCK_W, 128, width of the block, key and result.
- CORE_TIMEOUT, 32, maximum cycles from core_start to core_done. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot, single-cycle accept pulse.
- req_block  in  NUM_REQ*BLOCK_W  plaintext; requester i uses slice [i*BLOCK_W +: BLOCK_W].
- req_key  in  NUM_REQ*BLOCK_W  cipher key; same slicing as req_block.
- rsp_valid  out  NUM_REQ  one-hot; result available for the granted requester.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_block  out  BLOCK_W  result data, shared by all requesters.
- rsp_err  out  1  result invalid (timeout); qualified by rsp_valid.
- core_start  out  1  single-cycle launch pulse to the core.
- core_block  out  BLOCK_W  plaintext to the core.
- core_key  out  BLOCK_W  key to the core.
- core_done  in  1  core completion pulse.
- core_result  in  BLOCK_W  core ciphertext; valid while core_done=1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, while reset=0):
  - State goes to IDLE and the round-robin pointer to 0.
  - req_ready, rsp_valid, core_start, rsp_err and busy are all 0.
  - rsp_block, core_block and core_key are all 0.
  - Assertion mid-job abandons the job; any later core_done is ignored.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Scan req_valid starting at the pointer, wrapping modulo NUM_REQ.
  - The first set bit g wins: pulse req_ready[g] for this cycle, capture req_block[g] and req_key[g] into core_block/core_key, record g, go to ISSUE.
  - If no request is valid, stay in IDLE.
- ISSUE:
  - core_start=1 for exactly one cycle, then go to WAIT.
  - core_block and core_key hold stable from capture until the next capture.
- WAIT:
  - On core_done=1, register core_result into rsp_block, clear rsp_err, go to RESP.
  - core_done in any state other than WAIT is ignored.
  - core_done in the same cycle as core_start is not possible, because start is issued in ISSUE.
- RESP:
  - rsp_valid[g]=1, held with rsp_block stable until rsp_ready[g]=1.
  - On that handshake: rsp_valid goes to 0, pointer = (g+1) mod NUM_REQ, go to IDLE.
  - rsp_ready of non-granted requesters is ignored.
- Latency:
  - Request accepted in cycle T; core_start in T+1.
  - If core_done arrives in cycle D, rsp_valid is first high in D+1.
  - A new accept is possible the cycle after the response handshake.
- Fairness:
  - A requester that was just served has the lowest priority on the next scan.
  - Any continuously asserting requester is served within NUM_REQ jobs.
- Requester rules:
  - req_valid may drop without being accepted; no state is kept for it.
  - A requester may assert req_valid while its own response is pending. It is not re-accepted until RESP completes.
- busy = (state != IDLE).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter is cleared at core_start and increments each WAIT cycle.
  - If it reaches CORE_TIMEOUT without core_done: go to RESP with rsp_block=0 and rsp_err=1.
  - A core_done arriving after the timeout is ignored.
- Not defined:
  - No counter is built; WAIT lasts until core_done with no limit.
  - rsp_err is tied to 0.

Test Plan:
- Single job:
  - Stimulus: requester 0 sends block 0x00112233445566778899aabbccddeeff with key 0x000102030405060708090a0b0c0d0e0f. A core model returns 0x69c4e0d86a7b0430d8cdb78070b4c55a after 11 cycles.
  - Expect: req_ready[0] at T, core_start at T+1, rsp_valid[0] with that ciphertext at T+13; busy falls the cycle after rsp_ready[0].
- Round-robin:
  - Stimulus: all 4 req_valid held high, immediate rsp_ready.
  - Expect: grant order 0,1,2,3,0. Then with only requesters 1 and 3 active after a grant to 3, the next grant is 1.
- Response backpressure:
  - Stimulus: hold rsp_ready[2] low for 20 cycles.
  - Expect: rsp_valid[2] and rsp_block stay stable, no new req_ready pulse and no core_start. Release gives the handshake, and IDLE follows the next cycle.
- Stray signals:
  - Stimulus: pulse core_done during IDLE and RESP; assert rsp_ready[1] while requester 2 is granted.
  - Expect: no state change and rsp_block unchanged.
- Reset mid-WAIT:
  - Stimulus: drive reset low while in WAIT, then release; a core_done arrives afterwards.
  - Expect: all outputs 0 immediately, and the late core_done produces no rsp_valid.
- Timeout (ARB_TIMEOUT_EN defined, CORE_TIMEOUT=32):
  - Stimulus: the core never responds.
  - Expect: rsp_valid with rsp_err=1 and rsp_block=0 exactly 33 cycles after core_start.
  - Without the macro, the arbiter stays in WAIT indefinitely.

Source files
------------

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one iterative AES-128 core among NUM_REQ requesters.
// Optional macro ARB_TIMEOUT_EN adds a CORE_TIMEOUT watchdog on the WAIT state.
module aes_core_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BLOCK_W      = 128,
  parameter int CORE_TIMEOUT = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BLOCK_W-1:0]   req_block,
  input  logic [NUM_REQ*BLOCK_W-1:0]   req_key,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [BLOCK_W-1:0]           rsp_block,
  output logic                         rsp_err,
  output logic                         core_start,
  output logic [BLOCK_W-1:0]           core_block,
  output logic [BLOCK_W-1:0]           core_key,
  input  logic                         core_done,
  input  logic [BLOCK_W-1:0]           core_result,
  output logic                         busy
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   gnt;
  logic            found;
  int              idx;

  // Scan from the pointer so the last-served requester is checked last.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = IW'(idx);
      end
    end
  end

  // Ready is combinational so a request that drops is never accepted late.
  assign req_ready = (state == IDLE && found) ? (NUM_REQ'(1) << gnt) : '0;
  assign busy      = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(CORE_TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      sel        <= '0;
      core_start <= 1'b0;
      core_block <= '0;
      core_key   <= '0;
      rsp_valid  <= '0;
      rsp_block  <= '0;
`ifdef ARB_TIMEOUT_EN
      rsp_err    <= 1'b0;
      cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel        <= gnt;
            core_block <= req_block[gnt*BLOCK_W +: BLOCK_W];
            core_key   <= req_key[gnt*BLOCK_W +: BLOCK_W];
            core_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          core_start <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          cnt        <= '0;
`endif
          state      <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            rsp_block <= core_result;
`ifdef ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            rsp_valid <= NUM_REQ'(1) << sel;
            state     <= RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == CW'(CORE_TIMEOUT - 1)) begin
            rsp_block <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= NUM_REQ'(1) << sel;
            state     <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready[sel]) begin
            rsp_valid <= '0;
            ptr       <= (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter: single job, round-robin, backpressure, strays, reset, timeout.
module tb_aes_core_arbiter;
  localparam int NR = 4;
  localparam int BW = 128;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*BW-1:0] req_block, req_key;
  logic [BW-1:0]    rsp_block, core_block, core_key, core_result;
  logic             rsp_err, core_start, core_done, busy;

  int vecs = 0;
  int errs = 0;

  localparam logic [BW-1:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BW-1:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [BW-1:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_core_arbiter #(.NUM_REQ(NR), .BLOCK_W(BW), .CORE_TIMEOUT(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_block(req_block), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_block(rsp_block), .rsp_err(rsp_err),
    .core_start(core_start), .core_block(core_block), .core_key(core_key),
    .core_done(core_done), .core_result(core_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with req_valid set; runs one job with a 3-cycle core.
  task automatic serve(input logic [NR-1:0] exp_g, input logic [BW-1:0] res);
    int n = 0;
    #1;
    while (req_ready == '0 && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk("grant", BW'(req_ready), BW'(exp_g));
    @(negedge clk);
    chk("start", BW'(core_start), 1);
    repeat (2) @(negedge clk);
    core_done = 1'b1; core_result = res;
    @(negedge clk);
    core_done = 1'b0;
    chk("rsp_valid", BW'(rsp_valid), BW'(exp_g));
    chk("rsp_block", rsp_block, res);
    rsp_ready = exp_g;
    @(negedge clk);
    rsp_ready = '0;
    chk("idle_after_rsp", BW'(busy), 0);
  endtask

  initial begin
    logic [BW-1:0] held;
    int n;
    reset = 1'b0; req_valid = '0; rsp_ready = '0; core_done = 1'b0; core_result = '0;
    req_block = '0; req_key = '0;
    for (int i = 0; i < NR; i++) begin
      req_block[i*BW +: BW] = PT ^ BW'(i);
      req_key[i*BW +: BW]   = KEY ^ BW'(i << 8);
    end
    repeat (2) @(negedge clk);
    chk("rst_req_ready", BW'(req_ready), 0);
    chk("rst_rsp_valid", BW'(rsp_valid), 0);
    chk("rst_core_start", BW'(core_start), 0);
    chk("rst_rsp_err", BW'(rsp_err), 0);
    chk("rst_busy", BW'(busy), 0);
    chk("rst_rsp_block", rsp_block, 0);
    chk("rst_core_block", core_block, 0);
    chk("rst_core_key", core_key, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single job, 11-cycle core: accept T, start T+1, rsp_valid T+13.
    req_valid = 4'b0001; #1;
    chk("single_ready", BW'(req_ready), 4'b0001);
    @(negedge clk);
    req_valid = '0;
    chk("single_start", BW'(core_start), 1);
    chk("single_core_block", core_block, PT);
    chk("single_core_key", core_key, KEY);
    chk("single_busy", BW'(busy), 1);
    repeat (11) @(negedge clk);
    chk("single_start_once", BW'(core_start), 0);
    core_done = 1'b1; core_result = CT;
    chk("single_no_early_rsp", BW'(rsp_valid), 0);
    @(negedge clk);
    core_done = 1'b0; core_result = '0;
    chk("single_rsp_valid", BW'(rsp_valid), 4'b0001);
    chk("single_rsp_block", rsp_block, CT);
    chk("single_rsp_err", BW'(rsp_err), 0);
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    chk("single_busy_fall", BW'(busy), 0);
    chk("single_rsp_drop", BW'(rsp_valid), 0);

    // Round-robin from a fresh pointer.
    reset = 1'b0; @(negedge clk); reset = 1'b1; @(negedge clk);
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) serve(NR'(1) << (i % NR), CT ^ BW'(i));
    req_valid = 4'b1010;
    serve(4'b0010, CT);
    serve(4'b1000, CT);
    req_valid = '0;

    // Stray core_done in IDLE.
    core_done = 1'b1; core_result = 128'hdead;
    @(negedge clk);
    core_done = 1'b0;
    chk("stray_idle_busy", BW'(busy), 0);
    chk("stray_idle_rsp", BW'(rsp_valid), 0);

    // Backpressure on requester 2 with stray rsp_ready[1] and core_done.
    req_valid = 4'b0100; #1;
    chk("bp_grant", BW'(req_ready), 4'b0100);
    @(negedge clk);
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    core_done = 1'b1; core_result = CT;
    @(negedge clk);
    core_done = 1'b0; core_result = '0;
    held = rsp_block;
    chk("bp_block", held, CT);
    for (int i = 0; i < 20; i++) begin
      rsp_ready   = (i == 5) ? 4'b0010 : 4'b0000;
      core_done   = (i == 9);
      core_result = 128'hbad;
      @(negedge clk);
      chk("bp_hold_valid", BW'(rsp_valid), 4'b0100);
      chk("bp_hold_block", rsp_block, held);
      chk("bp_no_ready", BW'(req_ready), 0);
      chk("bp_no_start", BW'(core_start), 0);
    end
    core_done = 1'b0; rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = '0;
    chk("bp_idle", BW'(busy), 0);
    serve(4'b1000, CT);
    req_valid = '0;

    // Reset while in WAIT; a late core_done must be ignored.
    req_valid = 4'b0001;
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    reset = 1'b0; #1;
    chk("rstw_busy", BW'(busy), 0);
    chk("rstw_core_block", core_block, 0);
    chk("rstw_core_key", core_key, 0);
    chk("rstw_start", BW'(core_start), 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); core_done = 1'b1; core_result = CT;
    @(negedge clk); core_done = 1'b0;
    @(negedge clk);
    chk("rstw_late_done", BW'(rsp_valid), 0);
    chk("rstw_late_busy", BW'(busy), 0);

    // Core never answers.
    req_valid = 4'b0001;
    @(negedge clk); req_valid = '0;
    chk("to_start", BW'(core_start), 1);
    n = 0;
    while (rsp_valid == '0 && n < 60) begin @(negedge clk); n++; end
`ifdef ARB_TIMEOUT_EN
    chk("to_latency", BW'(n), 33);
    chk("to_err", BW'(rsp_err), 1);
    chk("to_block", rsp_block, 0);
    rsp_ready = 4'b0001; @(negedge clk); rsp_ready = '0;
`else
    chk("to_no_rsp", BW'(rsp_valid), 0);
    chk("to_still_busy", BW'(busy), 1);
`endif
    reset = 1'b0; @(negedge clk); reset = 1'b1; @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
